// File: rtl/dmem_common.sv
// Package: dmem_common
//
// Shared types and constants for the data-memory responder.
//   word_t        32-bit bus word
//   mmio_off_t    word offset inside the MMIO page (addr[7:2])
//   region_t      address decode result
//   MMIO_*        word offsets of the timer/scratch registers
//   merge_bytes   applies a per-byte write mask to a 32-bit word

package dmem_common;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  mmio_off_t;

    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_MMIO = 2'd1,
        REGION_NONE = 2'd2
    } region_t;

    // Word offsets; the byte offset is four times these (0x00, 0x04, ...).
    localparam mmio_off_t MMIO_MTIME_LO    = 6'h00;
    localparam mmio_off_t MMIO_MTIME_HI    = 6'h01;
    localparam mmio_off_t MMIO_MTIMECMP_LO = 6'h02;
    localparam mmio_off_t MMIO_MTIMECMP_HI = 6'h03;
    localparam mmio_off_t MMIO_SCRATCH     = 6'h04;

    // Byte lane n of new_word replaces lane n of old_word when mask[n] is set.
    function automatic word_t merge_bytes(input word_t      old_word,
                                          input word_t      new_word,
                                          input logic [3:0] mask);
        word_t result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Module: mmio_timer
//
// MMIO page contents: free-running 64-bit mtime, 64-bit mtimecmp, a 32-bit
// scratch register and the shadow that makes a lo-then-hi read of mtime
// tear-free. Writes are byte-masked and take effect at the edge they are
// presented; reads are registered (one cycle latency) and return the values
// held before that edge.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   sel_i            the current bus address falls in the MMIO page
//   read_enable_i    read request this cycle
//   offset_i         word offset inside the page (addr[7:2])
//   write_mask_i     per-byte write enable, 0 = no write
//   write_data_i     lane-aligned write data
//   read_data_o      registered read data; holds between reads
//   interrupt_o      registered timer interrupt level (mtime >= mtimecmp)

module mmio_timer
    import dmem_common::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sel_i,
    input  logic       read_enable_i,
    input  mmio_off_t  offset_i,
    input  logic [3:0] write_mask_i,
    input  word_t      write_data_i,
    output word_t      read_data_o,
    output logic       interrupt_o
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    word_t       scratch_q, scratch_d;
    word_t       shadow_q, shadow_d;
    word_t       rdata_q, rdata_d;
    logic        irq_q;
    logic        do_write;
    logic        do_read;

    assign do_write = sel_i && (write_mask_i != 4'b0000);
    assign do_read  = sel_i && read_enable_i;

    // Register update. A write to either mtime half replaces the written
    // bytes and the counter does not advance in that cycle.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        scratch_d  = scratch_q;
        if (do_write) begin
            case (offset_i)
                MMIO_MTIME_LO: begin
                    mtime_d = {mtime_q[63:32],
                               merge_bytes(mtime_q[31:0], write_data_i, write_mask_i)};
                end
                MMIO_MTIME_HI: begin
                    mtime_d = {merge_bytes(mtime_q[63:32], write_data_i, write_mask_i),
                               mtime_q[31:0]};
                end
                MMIO_MTIMECMP_LO: begin
                    mtimecmp_d = {mtimecmp_q[63:32],
                                  merge_bytes(mtimecmp_q[31:0], write_data_i, write_mask_i)};
                end
                MMIO_MTIMECMP_HI: begin
                    mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], write_data_i, write_mask_i),
                                  mtimecmp_q[31:0]};
                end
                MMIO_SCRATCH: begin
                    scratch_d = merge_bytes(scratch_q, write_data_i, write_mask_i);
                end
                default: ;
            endcase
        end
    end

    // Read port. Reading mtime_lo captures the matching upper half so a
    // following mtime_hi read cannot observe a carry that happened between
    // the two accesses.
    always_comb begin
        rdata_d  = rdata_q;
        shadow_d = shadow_q;
        if (do_read) begin
            case (offset_i)
                MMIO_MTIME_LO: begin
                    rdata_d  = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                MMIO_MTIME_HI:    rdata_d = shadow_q;
                MMIO_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                MMIO_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                MMIO_SCRATCH:     rdata_d = scratch_q;
                default:          rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            scratch_q  <= '0;
            shadow_q   <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            scratch_q  <= scratch_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
            // Compares the registered values, so the level trails a
            // crossing (or a mtimecmp rewrite) by one cycle.
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign read_data_o = rdata_q;
    assign interrupt_o = irq_q;

endmodule

// File: rtl/dmem_responder.sv
// Module: dmem_responder
//
// Responder end of the CPU data-memory bus. Decodes each access into the
// byte-writable RAM (0 .. RAM_WORDS*4-1), the 256-byte MMIO page at
// MMIO_BASE, or unmapped space, and returns read data one cycle later.
// RAM contents are not reset and start undefined; software loads them
// over the bus.
//
// Bus semantics: there is no ready/stall. Every cycle with read_enable_i=1
// is one read whose data appears on dmem_read_data_o after the next edge;
// every cycle with a nonzero write mask is one write committed at that edge.
// A read and write to the same word in the same cycle returns the old data.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   dmem_addr_i          byte address, bits [1:0] ignored
//   dmem_read_enable_i   read request this cycle
//   dmem_write_mask_i    per-byte write enable, 0 = no write
//   dmem_write_data_i    lane-aligned write data
//   dmem_read_data_o     read data, valid the cycle after the request
//   interrupt_o          timer interrupt level to the CPU

module dmem_responder
    import dmem_common::*;
#(
    parameter int unsigned RAM_WORDS = 4096,       // power of two
    parameter logic [31:0] MMIO_BASE = 32'hFF00_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] dmem_addr_i,
    input  logic        dmem_read_enable_i,
    input  logic [3:0]  dmem_write_mask_i,
    input  logic [31:0] dmem_write_data_i,
    output logic [31:0] dmem_read_data_o,
    output logic        interrupt_o
);

    localparam int unsigned IDX_W      = $clog2(RAM_WORDS);
    localparam int unsigned RAM_ADDR_W = IDX_W + 2;

    region_t          region;
    region_t          region_q;
    logic [IDX_W-1:0] ram_idx;
    logic             ram_re;
    logic [3:0]       ram_we;
    word_t            ram_q;
    word_t            mmio_rdata;
    logic             mmio_sel;
    logic             unused_addr_bits;

    word_t mem [RAM_WORDS];

    // Word access only; the low address bits carry no information.
    assign unused_addr_bits = ^dmem_addr_i[1:0];

    always_comb begin
        region = REGION_NONE;
        if (dmem_addr_i[31:RAM_ADDR_W] == '0) begin
            region = REGION_RAM;
        end else if (dmem_addr_i[31:8] == MMIO_BASE[31:8]) begin
            region = REGION_MMIO;
        end
    end

    assign ram_idx  = dmem_addr_i[RAM_ADDR_W-1:2];
    assign ram_re   = dmem_read_enable_i && (region == REGION_RAM);
    assign ram_we   = (region == REGION_RAM) ? dmem_write_mask_i : 4'b0000;
    assign mmio_sel = (region == REGION_MMIO);

    // Single-port RAM with per-byte enables, read-first. No reset so it
    // maps onto block RAM; the output mux below hides ram_q until a RAM
    // read has actually been issued.
    always_ff @(posedge clk_i) begin
        if (ram_re) begin
            ram_q <= mem[ram_idx];
        end
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) begin
                mem[ram_idx][8*b +: 8] <= dmem_write_data_i[8*b +: 8];
            end
        end
    end

    mmio_timer u_mmio_timer (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .sel_i         (mmio_sel),
        .read_enable_i (dmem_read_enable_i),
        .offset_i      (dmem_addr_i[7:2]),
        .write_mask_i  (dmem_write_mask_i),
        .write_data_i  (dmem_write_data_i),
        .read_data_o   (mmio_rdata),
        .interrupt_o   (interrupt_o)
    );

    // The region is captured alongside each read so the mux select lines
    // up with the data registers it chooses between. It only moves on a
    // read, which is what makes the output hold while idle. Resetting it
    // to REGION_NONE forces the output to zero immediately on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            region_q <= REGION_NONE;
        end else if (dmem_read_enable_i) begin
            region_q <= region;
        end
    end

    always_comb begin
        dmem_read_data_o = '0;
        case (region_q)
            REGION_RAM:  dmem_read_data_o = ram_q;
            REGION_MMIO: dmem_read_data_o = mmio_rdata;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: reset values, RAM byte lanes,
// read-first, decode boundaries, scratch, timer interrupt lag, mtime wrap
// with the hi shadow, and asynchronous reset during a read.

module tb_dmem_responder;

  localparam logic [31:0] MT_LO  = 32'hFF00_0000;
  localparam logic [31:0] MT_HI  = 32'hFF00_0004;
  localparam logic [31:0] CMP_LO = 32'hFF00_0008;
  localparam logic [31:0] CMP_HI = 32'hFF00_000C;
  localparam logic [31:0] SCR    = 32'hFF00_0010;
  localparam logic [31:0] UNUSED_OFF = 32'hFF00_0014;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        re;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  dmem_responder #(
    .RAM_WORDS (4096),
    .MMIO_BASE (32'hFF00_0000)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .dmem_addr_i        (addr),
    .dmem_read_enable_i (re),
    .dmem_write_mask_i  (mask),
    .dmem_write_data_i  (wdata),
    .dmem_read_data_o   (rdata),
    .interrupt_o        (irq)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, take the edge, then compare the read result
  // (if any) against the head of the expected queue.
  task automatic bus(input string tag, input logic [31:0] a, input logic r,
                     input logic [3:0] m, input logic [31:0] d, input logic [31:0] e);
    addr = a; re = r; mask = m; wdata = d;
    if (r) exp_q.push_back(e);
    @(posedge clk);
    #1;
    addr = '0; re = 1'b0; mask = '0; wdata = '0;
    if (r) check(tag, rdata, exp_q.pop_front());
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    bus("wr", a, 1'b0, m, d, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    bus(tag, a, 1'b1, 4'b0000, 32'd0, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus("idle", 32'd0, 1'b0, 4'b0000, 32'd0, 32'd0);
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    addr = '0; re = 1'b0; mask = '0; wdata = '0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    rd("rst_cmp_lo", CMP_LO, 32'hFFFF_FFFF);
    rd("rst_cmp_hi", CMP_HI, 32'hFFFF_FFFF);
    rd("rst_shadow", MT_HI, 32'd0);

    // RAM byte lanes
    wr(32'h40, 4'b1111, 32'hDEAD_BEEF);
    wr(32'h40, 4'b0001, 32'h0000_0055);
    rd("ram_lane0", 32'h40, 32'hDEAD_BE55);
    idle(2);
    check("ram_hold", rdata, 32'hDEAD_BE55);
    wr(32'h48, 4'b0110, 32'hAABB_CCDD);
    wr(32'h48, 4'b1001, 32'h1100_0022);
    rd("ram_lanes_mid", 32'h48, 32'h11BB_CC22);

    // read-first
    wr(32'h44, 4'b1111, 32'd0);
    bus("read_first_old", 32'h44, 1'b1, 4'b1111, 32'h1234_5678, 32'd0);
    rd("read_first_new", 32'h44, 32'h1234_5678);

    // decode boundaries: last RAM word, first address past RAM, unmapped
    wr(32'h0, 4'b1111, 32'h1111_1111);
    wr(32'h3FFC, 4'b1111, 32'hCAFE_F00D);
    wr(32'h4000, 4'b1111, 32'hFFFF_FFFF);
    rd("ram_last", 32'h3FFC, 32'hCAFE_F00D);
    rd("past_ram", 32'h4000, 32'd0);
    rd("ram_word0", 32'h0, 32'h1111_1111);
    rd("unmapped", 32'h8000_0000, 32'd0);

    // scratch and unused MMIO offset, back-to-back reads across regions
    wr(SCR, 4'b1111, 32'hA5A5_A5A5);
    wr(SCR, 4'b0010, 32'h0000_3C00);
    wr(UNUSED_OFF, 4'b1111, 32'h5555_5555);
    rd("b2b_ram", 32'h44, 32'h1234_5678);
    rd("b2b_scratch", SCR, 32'hA5A5_3CA5);
    rd("b2b_unused_off", UNUSED_OFF, 32'd0);
    rd("b2b_ram2", 32'h40, 32'hDEAD_BE55);

    // timer: zero mtime, mtimecmp = 100, watch the lagged interrupt.
    // k counts edges after the one that wrote mtime_lo = 0, so mtime = k.
    wr(MT_HI, 4'b1111, 32'd0);
    wr(MT_LO, 4'b1111, 32'd0);
    wr(CMP_HI, 4'b1111, 32'd0);
    wr(CMP_LO, 4'b1111, 32'd100);
    for (int k = 3; k <= 110; k++) begin
      bus("mtime_at_irq", MT_LO, (k == 102), 4'b0000, 32'd0, 32'd101);
      check("irq_lag", {31'd0, irq}, {31'd0, (k >= 101)});
    end
    wr(CMP_LO, 4'b1111, 32'hFFFF_FFFF);
    check("irq_held_at_write", {31'd0, irq}, 32'd1);
    idle(1);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // wrap and tear-free hi read
    wr(MT_HI, 4'b1111, 32'hFFFF_FFFF);
    wr(MT_LO, 4'b1111, 32'hFFFF_FFFE);
    rd("wrap_lo", MT_LO, 32'hFFFF_FFFE);
    rd("wrap_hi_shadow", MT_HI, 32'hFFFF_FFFF);
    rd("after_wrap_lo", MT_LO, 32'd0);
    rd("after_wrap_hi", MT_HI, 32'd0);

    // asynchronous reset in the middle of a read
    rd("pre_reset_ram", 32'h40, 32'hDEAD_BE55);
    addr = 32'h40; re = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rdata", rdata, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    addr = '0; re = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    check("post_rst_rdata", rdata, 32'd0);
    rd("post_rst_cmp_lo", CMP_LO, 32'hFFFF_FFFF);
    rd("post_rst_scratch", SCR, 32'd0);
    rd("ram_survives_rst", 32'h40, 32'hDEAD_BE55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
